// File: rtl/rf_stream_selector.sv
// Receptive-field streamer: walks every (output row, column group) of an image and emits one
// registered packet of P FxF windows per step over a valid/ready handshake.
module rf_stream_selector #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int S          = 1,
  parameter int P          = 14
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [0:D*H*W*DATA_WIDTH-1]       image,
  input  logic                              rf_ready,
  output logic                              rf_valid,
  output logic [0:P*D*F*F*DATA_WIDTH-1]     receptiveField,
  output logic [15:0]                       rf_row,
  output logic [15:0]                       rf_group,
  output logic [P-1:0]                      rf_mask,
  output logic                              busy,
  output logic                              done,
  output logic [1:0]                        dbg_state_o
);

  localparam int OH = (H - F) / S + 1;
  localparam int OW = (W - F) / S + 1;
  localparam int G  = (OW + P - 1) / P;
  localparam int M  = P * D * F * F * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   row_q, row_d;
  logic [15:0]   group_q, group_d;
  logic [0:M-1]  pkt_q, pkt_d;
  logic [P-1:0]  mask_q, mask_d;
  logic [15:0]   rf_row_q, rf_group_q;
  logic          last_group, last_row;

  // Window gather for the current (row_q, group_q); lanes past the last output column stay zero.
  always_comb begin
    pkt_d  = '0;
    mask_d = '0;
    for (int c = 0; c < P; c++) begin
      if (int'(group_q) * P + c < OW) begin
        mask_d[c] = 1'b1;
        for (int k = 0; k < D; k++) begin
          for (int i = 0; i < F; i++) begin
            for (int j = 0; j < F; j++) begin
              pkt_d[(((c * D + k) * F + i) * F + j) * DATA_WIDTH +: DATA_WIDTH] =
                image[(k * H * W + (int'(row_q) * S + i) * W
                       + (int'(group_q) * P + c) * S + j) * DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  assign last_group = (int'(group_q) == G - 1);
  assign last_row   = (int'(row_q) == OH - 1);

  // Handshake: a packet is offered while rf_valid is high and is consumed on the rising edge
  // where rf_valid & rf_ready; the packet and its tags are held unchanged until then.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    group_d = group_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          row_d   = '0;
          group_d = '0;
        end
      end
      LOAD: state_d = EMIT;
      EMIT: begin
        if (rf_ready) begin
          if (last_group) begin
            group_d = '0;
            if (last_row) begin
              state_d = DONE;
            end else begin
              row_d   = row_q + 16'd1;
              state_d = LOAD;
            end
          end else begin
            group_d = group_q + 16'd1;
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      group_q    <= '0;
      pkt_q      <= '0;
      mask_q     <= '0;
      rf_row_q   <= '0;
      rf_group_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      group_q <= group_d;
      if (state_q == LOAD) begin
        pkt_q      <= pkt_d;
        mask_q     <= mask_d;
        rf_row_q   <= row_q;
        rf_group_q <= group_q;
      end
    end
  end

  assign rf_valid       = (state_q == EMIT);
  assign busy           = (state_q == LOAD) || (state_q == EMIT);
  assign done           = (state_q == DONE);
  assign receptiveField = pkt_q;
  assign rf_row         = rf_row_q;
  assign rf_group       = rf_group_q;
  assign rf_mask        = mask_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rf_stream_selector.sv
// Bench for rf_stream_selector: three parameter sets driven in turn, checked against
// hand-computed packet words and the row/group/mask stepping order.
module tb_rf_stream_selector;

  localparam int M0 = 14 * 1 * 5 * 5 * 32;
  localparam int M1 = 2 * 1 * 3 * 3 * 32;
  localparam int M2 = 4 * 2 * 3 * 3 * 32;

  localparam int CFG_P  [3] = '{14, 2, 4};
  localparam int CFG_OW [3] = '{28, 3, 4};
  localparam int CFG_OH [3] = '{28, 3, 4};
  localparam int CFG_G  [3] = '{2, 2, 1};
  localparam int CFG_N  [3] = '{56, 6, 4};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic       rdy;

  logic [0:32*32*32-1] img0;
  logic [0:8*8*32-1]   img1;
  logic [0:2*6*6*32-1] img2;

  logic v0, v1, v2, b0, b1, b2, d0, d1, d2;
  logic [0:M0-1] rf0;
  logic [0:M1-1] rf1;
  logic [0:M2-1] rf2;
  logic [15:0] row0, row1, row2, grp0, grp1, grp2;
  logic [13:0] mask0;
  logic [1:0]  mask1;
  logic [3:0]  mask2;
  logic [1:0]  dbg0, dbg1, dbg2;

  rf_stream_selector u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .image(img0), .rf_ready(rdy),
    .rf_valid(v0), .receptiveField(rf0), .rf_row(row0), .rf_group(grp0), .rf_mask(mask0),
    .busy(b0), .done(d0), .dbg_state_o(dbg0));

  rf_stream_selector #(.DATA_WIDTH(32), .D(1), .H(8), .W(8), .F(3), .S(2), .P(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .image(img1), .rf_ready(rdy),
    .rf_valid(v1), .receptiveField(rf1), .rf_row(row1), .rf_group(grp1), .rf_mask(mask1),
    .busy(b1), .done(d1), .dbg_state_o(dbg1));

  rf_stream_selector #(.DATA_WIDTH(32), .D(2), .H(6), .W(6), .F(3), .S(1), .P(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .image(img2), .rf_ready(rdy),
    .rf_valid(v2), .receptiveField(rf2), .rf_row(row2), .rf_group(grp2), .rf_mask(mask2),
    .busy(b2), .done(d2), .dbg_state_o(dbg2));

  int sel;
  logic        cur_valid, cur_busy, cur_done;
  logic [15:0] cur_row, cur_group;
  logic [13:0] cur_mask;

  always_comb begin
    cur_valid = v0; cur_busy = b0; cur_done = d0;
    cur_row = row0; cur_group = grp0; cur_mask = mask0;
    case (sel)
      1: begin
        cur_valid = v1; cur_busy = b1; cur_done = d1;
        cur_row = row1; cur_group = grp1; cur_mask = {12'b0, mask1};
      end
      2: begin
        cur_valid = v2; cur_busy = b2; cur_done = d2;
        cur_row = row2; cur_group = grp2; cur_mask = {10'b0, mask2};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] word_of(input int s, input int w);
    case (s)
      1:       return rf1[w*32 +: 32];
      2:       return rf2[w*32 +: 32];
      default: return rf0[w*32 +: 32];
    endcase
  endfunction

  // scoreboard
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          cfg;
    int          xfer;
    int          word;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int c, input int x, input int w, input int e);
    vec_t v;
    v.cfg = c; v.xfer = x; v.word = w; v.exp = e;
    vecs.push_back(v);
  endtask

  // driver: one full sweep of DUT s with optional stall, repeated start, or mid-sweep reset
  task automatic run(input int s, input int bp_at, input int restart_at, input int reset_at);
    int xfer, done_cnt, hold, rs_left;
    bit finished;
    logic [0:M0-1] snap;
    logic [15:0]   snap_row, snap_grp;
    logic [13:0]   exp_mask;
    xfer = 0; done_cnt = 0; hold = 0; rs_left = 0; finished = 0;
    snap = '0; snap_row = '0; snap_grp = '0;
    sel = s;
    rdy = 1'b1;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk($sformatf("cfg%0d load_valid", s), cur_valid, 1'b0);
    chk($sformatf("cfg%0d load_busy", s), cur_busy, 1'b1);
    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      @(negedge clk);
      if (rs_left > 0) rs_left--;
      else start_v[s] = 1'b0;
      if (cyc == 0) chk($sformatf("cfg%0d first_valid", s), cur_valid, 1'b1);
      if (cur_done) begin
        done_cnt++;
        chk($sformatf("cfg%0d done_busy", s), cur_busy, 1'b0);
        chk($sformatf("cfg%0d done_valid", s), cur_valid, 1'b0);
        finished = 1;
      end else if (cur_valid) begin
        if (xfer == reset_at) begin
          reset = 1'b1;
          #1;
          chk("rst_valid", v0, 1'b0);
          chk("rst_busy", b0, 1'b0);
          chk("rst_done", d0, 1'b0);
          chk("rst_row", row0, 16'd0);
          chk("rst_group", grp0, 16'd0);
          chk("rst_mask", mask0, 14'd0);
          chk("rst_data_zero", (rf0 == '0), 1'b1);
          #1 reset = 1'b0;
          @(negedge clk);
          chk("rst_no_done", d0, 1'b0);
          chk("rst_idle_busy", b0, 1'b0);
          return;
        end else if (xfer == bp_at && hold < 5) begin
          rdy = 1'b0;
          if (hold == 0) begin
            snap = rf0; snap_row = cur_row; snap_grp = cur_group;
          end else begin
            chk($sformatf("bp%0d valid", hold), cur_valid, 1'b1);
            chk($sformatf("bp%0d row", hold), cur_row, snap_row);
            chk($sformatf("bp%0d group", hold), cur_group, snap_grp);
            chk($sformatf("bp%0d data", hold), (rf0 == snap), 1'b1);
          end
          hold++;
        end else begin
          rdy = 1'b1;
          exp_mask = '0;
          for (int c = 0; c < CFG_P[s]; c++)
            if ((xfer % CFG_G[s]) * CFG_P[s] + c < CFG_OW[s]) exp_mask[c] = 1'b1;
          chk($sformatf("cfg%0d x%0d row", s, xfer), cur_row, xfer / CFG_G[s]);
          chk($sformatf("cfg%0d x%0d group", s, xfer), cur_group, xfer % CFG_G[s]);
          chk($sformatf("cfg%0d x%0d mask", s, xfer), cur_mask, exp_mask);
          chk($sformatf("cfg%0d x%0d busy", s, xfer), cur_busy, 1'b1);
          if (s == 1 && (xfer % 2) == 1)
            chk($sformatf("cfg1 x%0d partial_mask", xfer), cur_mask, 14'b01);
          foreach (vecs[i])
            if (vecs[i].cfg == s && vecs[i].xfer == xfer)
              chk($sformatf("cfg%0d x%0d word%0d", s, xfer, vecs[i].word),
                  word_of(s, vecs[i].word), vecs[i].exp);
          if (xfer == restart_at) begin
            start_v[s] = 1'b1;
            rs_left = 1;
          end
          xfer++;
        end
      end else begin
        rdy = 1'b1;
      end
    end
    chk($sformatf("cfg%0d sweep_finished", s), finished, 1'b1);
    chk($sformatf("cfg%0d transfers", s), xfer, CFG_N[s]);
    chk($sformatf("cfg%0d done_pulses", s), done_cnt, 1);
    @(negedge clk);
    chk($sformatf("cfg%0d post_done", s), cur_done, 1'b0);
    chk($sformatf("cfg%0d post_busy", s), cur_busy, 1'b0);
    chk($sformatf("cfg%0d post_valid", s), cur_valid, 1'b0);
    chk($sformatf("cfg%0d held_row", s), cur_row, CFG_OH[s] - 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_v = '0; rdy = 1'b0; sel = 0;
    for (int p = 0; p < 32*32; p++) img0[p*32 +: 32] = p;
    for (int p = 0; p < 8*8; p++)   img1[p*32 +: 32] = p;
    for (int p = 0; p < 2*6*6; p++) img2[p*32 +: 32] = p;

    // default geometry, 25 words per lane
    add_vec(0, 0, 0, 0);     add_vec(0, 0, 4, 4);     add_vec(0, 0, 5, 32);
    add_vec(0, 0, 9, 36);    add_vec(0, 0, 24, 132);  add_vec(0, 0, 25, 1);
    add_vec(0, 1, 0, 14);    add_vec(0, 1, 325, 27);  add_vec(0, 1, 349, 159);
    add_vec(0, 2, 0, 32);    add_vec(0, 3, 0, 46);    add_vec(0, 4, 0, 64);
    add_vec(0, 55, 349, 1023);
    // 8x8, F=3, S=2, P=2: 9 words per lane, lane 1 of group 1 is empty
    add_vec(1, 0, 0, 0);     add_vec(1, 0, 8, 18);    add_vec(1, 0, 9, 2);
    add_vec(1, 1, 0, 4);     add_vec(1, 1, 9, 0);     add_vec(1, 1, 13, 0);
    add_vec(1, 1, 17, 0);    add_vec(1, 2, 9, 18);    add_vec(1, 4, 0, 32);
    add_vec(1, 5, 8, 54);    add_vec(1, 5, 9, 0);
    // D=2, 6x6, F=3, P=4: 18 words per lane, channel 1 starts at word 9 of each lane
    add_vec(2, 0, 0, 0);     add_vec(2, 0, 2, 2);     add_vec(2, 0, 3, 6);
    add_vec(2, 0, 9, 36);    add_vec(2, 0, 10, 37);   add_vec(2, 0, 11, 38);
    add_vec(2, 0, 17, 50);   add_vec(2, 0, 54, 3);    add_vec(2, 0, 63, 39);
    add_vec(2, 3, 0, 18);    add_vec(2, 3, 71, 71);

    repeat (3) @(negedge clk);
    chk("reset_valid", v0, 1'b0);
    chk("reset_busy", b0, 1'b0);
    chk("reset_done", d0, 1'b0);
    chk("reset_row", row0, 16'd0);
    chk("reset_group", grp0, 16'd0);
    chk("reset_mask", mask0, 14'd0);
    chk("reset_data_zero", (rf0 == '0), 1'b1);
    chk("reset_state", dbg0, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    run(0, -1, -1, -1);
    run(1, -1, -1, -1);
    run(2, -1, -1, -1);
    run(0, 3, 10, -1);
    run(0, -1, -1, 20);
    run(0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
